// File: rtl/burst_arb_pkg.sv
// rtl/burst_arb_pkg.sv - shared types and grant encodings for the two-port burst write arbiter
package burst_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [NUM_REQ-1:0] GRANT_NONE = 2'b00;
    localparam logic [NUM_REQ-1:0] GRANT_RQ0  = 2'b01;
    localparam logic [NUM_REQ-1:0] GRANT_RQ1  = 2'b10;

endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational two-way round-robin pick producing a one-hot winner
module rr_grant2
    import burst_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] request,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] winner
);

    // last_grant holds the index of the previous owner; a tie goes to the other one
    always_comb begin
        winner = GRANT_NONE;
        case (request)
            2'b01:   winner = GRANT_RQ0;
            2'b10:   winner = GRANT_RQ1;
            2'b11:   winner = last_grant ? GRANT_RQ0 : GRANT_RQ1;
            default: winner = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/burst_write_arbiter.sv
// rtl/burst_write_arbiter.sv - grants whole Avalon-MM write bursts round-robin between two requesters
module burst_write_arbiter
    import burst_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [ADDRESS_WIDTH-1:0]     rq0_address,
    input  logic                         rq0_write,
    input  logic [DATA_WIDTH-1:0]        rq0_writedata,
    input  logic [BURST_WIDTH-1:0]       rq0_burstcount,
    input  logic [BYTE_ENABLE_WIDTH-1:0] rq0_byteenable,
    output logic                         rq0_waitrequest,

    input  logic [ADDRESS_WIDTH-1:0]     rq1_address,
    input  logic                         rq1_write,
    input  logic [DATA_WIDTH-1:0]        rq1_writedata,
    input  logic [BURST_WIDTH-1:0]       rq1_burstcount,
    input  logic [BYTE_ENABLE_WIDTH-1:0] rq1_byteenable,
    output logic                         rq1_waitrequest,

    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,

    output logic [NUM_REQ-1:0]           grant,
    output logic                         burst_done
);

    state_t                  state, state_next;
    logic [NUM_REQ-1:0]      owner, owner_next;
    logic [BURST_WIDTH-1:0]  beats_left, beats_left_next;
    logic                    last_grant, last_grant_next;
    logic                    burst_done_next;
    logic [NUM_REQ-1:0]      winner;
    logic [BURST_WIDTH-1:0]  win_count;
    logic                    accepted;

    rr_grant2 u_rr_grant2 (
        .request    ({rq1_write, rq0_write}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= GRANT_NONE;
            beats_left <= '0;
            last_grant <= 1'b1;
            burst_done <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            beats_left <= beats_left_next;
            last_grant <= last_grant_next;
            burst_done <= burst_done_next;
        end
    end

    assign grant = owner;

    // Write traffic is a pure combinational pass-through of the owner's signals
    always_comb begin
        master_address    = '0;
        master_write      = 1'b0;
        master_writedata  = '0;
        master_burstcount = '0;
        master_byteenable = '0;
        rq0_waitrequest   = 1'b1;
        rq1_waitrequest   = 1'b1;
        if (state == BURST) begin
            if (owner == GRANT_RQ1) begin
                master_address    = rq1_address;
                master_write      = rq1_write;
                master_writedata  = rq1_writedata;
                master_burstcount = rq1_burstcount;
                master_byteenable = rq1_byteenable;
                rq1_waitrequest   = master_waitrequest;
            end else begin
                master_address    = rq0_address;
                master_write      = rq0_write;
                master_writedata  = rq0_writedata;
                master_burstcount = rq0_burstcount;
                master_byteenable = rq0_byteenable;
                rq0_waitrequest   = master_waitrequest;
            end
        end
    end

    assign accepted  = master_write & ~master_waitrequest;
    assign win_count = (winner == GRANT_RQ1) ? rq1_burstcount : rq0_burstcount;

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        beats_left_next = beats_left;
        last_grant_next = last_grant;
        burst_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (winner != GRANT_NONE) begin
                    state_next      = BURST;
                    owner_next      = winner;
                    // A zero burstcount is treated as a single-beat burst
                    beats_left_next = (win_count == '0) ? BURST_WIDTH'(1) : win_count;
                end
            end
            BURST: begin
                if (accepted) begin
                    beats_left_next = beats_left - BURST_WIDTH'(1);
                    if (beats_left == BURST_WIDTH'(1)) begin
                        state_next      = IDLE;
                        owner_next      = GRANT_NONE;
                        last_grant_next = (owner == GRANT_RQ1);
                        burst_done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                owner_next = GRANT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_write_arbiter.sv
// tb/tb_burst_write_arbiter.sv - randomized and directed bench for burst_write_arbiter
`timescale 1ns/1ps
module tb_burst_write_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bc;
        int          gap;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rq_addr [2];
    logic [31:0] rq_data [2];
    logic [3:0]  rq_bc [2];
    logic [3:0]  rq_be [2];
    logic        rq_write [2];
    logic        rq0_wait, rq1_wait;
    logic [31:0] master_address, master_writedata;
    logic        master_write;
    logic [3:0]  master_burstcount, master_byteenable;
    logic        master_waitrequest = 1'b0;
    logic [1:0]  grant;
    logic        burst_done;

    int errors = 0;
    int checks = 0;

    burst_t      plan [2][16];
    int          plan_n [2];
    int          plan_i [2];
    bit          active [2];
    int          beat [2];
    int          eff [2];
    int          gap_cnt [2];
    logic [31:0] base [2];
    int          wait_mode;
    bit          allow_drop;

    int          mowner, mleft, mlast;
    bit          mdone;

    int          cyc, done_cyc, beats_seen;
    int          order[$];
    int          grant_cyc[$];
    logic [1:0]  prev_grant;
    logic [31:0] first_addr;

    always #5 clk = ~clk;

    burst_write_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .rq0_address        (rq_addr[0]),
        .rq0_write          (rq_write[0]),
        .rq0_writedata      (rq_data[0]),
        .rq0_burstcount     (rq_bc[0]),
        .rq0_byteenable     (rq_be[0]),
        .rq0_waitrequest    (rq0_wait),
        .rq1_address        (rq_addr[1]),
        .rq1_write          (rq_write[1]),
        .rq1_writedata      (rq_data[1]),
        .rq1_burstcount     (rq_bc[1]),
        .rq1_byteenable     (rq_be[1]),
        .rq1_waitrequest    (rq1_wait),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_burstcount  (master_burstcount),
        .master_byteenable  (master_byteenable),
        .master_waitrequest (master_waitrequest),
        .grant              (grant),
        .burst_done         (burst_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mowner = -1;
        mleft  = 0;
        mlast  = 1;
        mdone  = 1'b0;
    endtask

    task automatic clear_plans();
        for (int n = 0; n < 2; n++) begin
            plan_n[n] = 0; plan_i[n] = 0; active[n] = 1'b0; beat[n] = 0; gap_cnt[n] = 0;
            rq_write[n] = 1'b0; rq_addr[n] = '0; rq_data[n] = '0; rq_bc[n] = '0; rq_be[n] = '0;
        end
    endtask

    task automatic add_burst(input int n, input logic [31:0] addr, input logic [3:0] bc, input int gap);
        plan[n][plan_n[n]] = '{addr: addr, bc: bc, gap: gap};
        plan_n[n]++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        master_waitrequest = 1'b0;
        clear_plans();
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_master_write", 64'(master_write), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_waitrequest", 64'({rq1_wait, rq0_wait}), 64'h3);
        chk("reset_burst_done", 64'(burst_done), 64'd0);
        chk("reset_master_fields", 64'({master_address, master_burstcount, master_byteenable}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expected outputs for the current cycle come from the plain-integer model state
    task automatic check_cycle();
        int         o;
        logic [1:0] eg, ew;
        bit         owr;
        o   = mowner;
        eg  = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        owr = (o >= 0) ? rq_write[o] : 1'b0;
        ew  = 2'b11;
        if (o == 0) ew[0] = master_waitrequest;
        else if (o == 1) ew[1] = master_waitrequest;
        chk("grant", 64'(grant), 64'(eg));
        chk("burst_done", 64'(burst_done), 64'(mdone));
        chk("rq_waitrequest", 64'({rq1_wait, rq0_wait}), 64'(ew));
        chk("master_write", 64'(master_write), 64'(owr));
        if (o >= 0) begin
            chk("master_address", 64'(master_address), 64'(rq_addr[o]));
            chk("master_writedata", 64'(master_writedata), 64'(rq_data[o]));
            chk("master_burstcount", 64'(master_burstcount), 64'(rq_bc[o]));
            chk("master_byteenable", 64'(master_byteenable), 64'(rq_be[o]));
            if (owr && !master_waitrequest)
                chk("beat_order", 64'(master_writedata), 64'(base[o] + 32'(beat[o])));
        end else begin
            chk("idle_master_fields", 64'({master_address, master_burstcount, master_byteenable}), 64'd0);
            chk("idle_master_data", 64'(master_writedata), 64'd0);
        end
        if (master_write && !master_waitrequest) begin
            beats_seen++;
            if (beats_seen == 1) first_addr = master_address;
        end
        if (burst_done && done_cyc < 0) done_cyc = cyc;
        if (prev_grant == 2'b00 && grant != 2'b00) begin
            order.push_back(grant[1] ? 1 : 0);
            grant_cyc.push_back(cyc);
        end
        prev_grant = grant;
    endtask

    task automatic step_model();
        int w, acc;
        acc   = -1;
        mdone = 1'b0;
        if (mowner < 0) begin
            if (rq_write[0] || rq_write[1]) begin
                if (rq_write[0] && rq_write[1]) w = (mlast == 1) ? 0 : 1;
                else w = rq_write[0] ? 0 : 1;
                mowner = w;
                mleft  = (rq_bc[w] == 4'd0) ? 1 : int'(rq_bc[w]);
            end
        end else if (rq_write[mowner] && !master_waitrequest) begin
            acc = mowner;
            mleft--;
            if (mleft == 0) begin
                mlast  = mowner;
                mowner = -1;
                mdone  = 1'b1;
            end
        end
        if (acc >= 0) begin
            beat[acc]++;
            if (beat[acc] == eff[acc]) begin
                active[acc] = 1'b0;
                plan_i[acc]++;
                if (plan_i[acc] < plan_n[acc]) gap_cnt[acc] = plan[acc][plan_i[acc]].gap;
            end
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            if (!active[n] && plan_i[n] < plan_n[n]) begin
                if (gap_cnt[n] == 0) begin
                    active[n] = 1'b1;
                    beat[n]   = 0;
                    base[n]   = $urandom;
                    rq_be[n]  = 4'($urandom_range(1, 15));
                    eff[n]    = (plan[n][plan_i[n]].bc == 4'd0) ? 1 : int'(plan[n][plan_i[n]].bc);
                end else begin
                    gap_cnt[n]--;
                end
            end
            if (active[n]) begin
                rq_addr[n]  = plan[n][plan_i[n]].addr;
                rq_bc[n]    = plan[n][plan_i[n]].bc;
                rq_data[n]  = base[n] + 32'(beat[n]);
                rq_write[n] = !(allow_drop && beat[n] > 0 && $urandom_range(0, 3) == 0);
            end else begin
                rq_write[n] = 1'b0;
                rq_addr[n]  = $urandom;
                rq_data[n]  = $urandom;
                rq_bc[n]    = 4'($urandom_range(0, 15));
                rq_be[n]    = 4'($urandom_range(0, 15));
            end
        end
        case (wait_mode)
            1:       master_waitrequest = ($urandom_range(0, 2) == 0);
            2:       master_waitrequest = (cyc >= 3 && cyc <= 5);
            default: master_waitrequest = 1'b0;
        endcase
    endtask

    function automatic bit all_done();
        return plan_i[0] >= plan_n[0] && plan_i[1] >= plan_n[1] && mowner < 0;
    endfunction

    task automatic run_phase(input string name, input int max_cycles, input int reset_at);
        cyc = 0; done_cyc = -1; beats_seen = 0; first_addr = '0;
        order.delete();
        grant_cyc.delete();
        prev_grant = grant;
        for (int n = 0; n < 2; n++) begin
            plan_i[n]  = 0;
            active[n]  = 1'b0;
            gap_cnt[n] = (plan_n[n] > 0) ? plan[n][0].gap : 0;
        end
        @(posedge clk);
        #1;
        drive();
        while (cyc < max_cycles && (!all_done() || mdone)) begin
            @(negedge clk);
            check_cycle();
            if (cyc == reset_at) begin
                reset = 1'b1;
                #1;
                chk({name, "_async_master_write"}, 64'(master_write), 64'd0);
                chk({name, "_async_grant"}, 64'(grant), 64'd0);
                clear_plans();
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            step_model();
            @(posedge clk);
            #1;
            cyc++;
            drive();
        end
        chk({name, "_complete"}, 64'(all_done()), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_d [5];
        wait_mode  = 0;
        allow_drop = 1'b0;

        // rq0 alone, 8 beats, no stalls
        do_reset();
        add_burst(0, 32'h3800_0000, 4'd8, 0);
        run_phase("single", 100, -1);
        chk("single_first_grant_cycle", 64'(grant_cyc.size() > 0 ? grant_cyc[0] : -1), 64'd1);
        chk("single_done_cycle", 64'(done_cyc), 64'd9);
        chk("single_beats", 64'(beats_seen), 64'd8);
        chk("single_first_addr", 64'(first_addr), 64'h3800_0000);

        // simultaneous first requests after reset: rq0 then rq1 after one idle cycle
        do_reset();
        add_burst(0, 32'h1000_0000, 4'd4, 0);
        add_burst(1, 32'h2000_0000, 4'd3, 0);
        run_phase("tie", 100, -1);
        chk("tie_grants", 64'(order.size()), 64'd2);
        chk("tie_first_owner", 64'(order.size() > 0 ? order[0] : -1), 64'd0);
        chk("tie_second_grant_cycle", 64'(grant_cyc.size() > 1 ? grant_cyc[1] : -1), 64'd6);
        chk("tie_beats", 64'(beats_seen), 64'd7);

        // stalls mid-burst
        do_reset();
        wait_mode = 2;
        add_burst(0, 32'h3800_0100, 4'd8, 0);
        run_phase("stall", 100, -1);
        wait_mode = 0;
        chk("stall_done_cycle", 64'(done_cyc), 64'd12);
        chk("stall_beats", 64'(beats_seen), 64'd8);

        // back-to-back requests alternate
        do_reset();
        for (int i = 0; i < 3; i++) add_burst(0, 32'h4000_0000 + 32'(i * 64), 4'd2, 0);
        for (int i = 0; i < 2; i++) add_burst(1, 32'h5000_0000 + 32'(i * 64), 4'd2, 0);
        run_phase("alternate", 200, -1);
        exp_d = '{0, 1, 0, 1, 0};
        chk("alternate_grants", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("alternate_owner", 64'(order.size() > i ? order[i] : -1), 64'(exp_d[i]));

        // async reset during beat 4, then a tie goes to rq0
        do_reset();
        add_burst(0, 32'h3800_0200, 4'd8, 0);
        run_phase("midreset", 100, 4);
        add_burst(0, 32'h6000_0000, 4'd2, 0);
        add_burst(1, 32'h7000_0000, 4'd2, 0);
        run_phase("postreset", 100, -1);
        chk("postreset_first_owner", 64'(order.size() > 0 ? order[0] : -1), 64'd0);

        // burstcount 0 is a single beat
        do_reset();
        add_burst(1, 32'h3800_0300, 4'd0, 0);
        run_phase("zero_count", 50, -1);
        chk("zero_count_beats", 64'(beats_seen), 64'd1);
        chk("zero_count_done_cycle", 64'(done_cyc), 64'd2);

        // randomized traffic with stalls and dropped write strobes
        do_reset();
        wait_mode  = 1;
        allow_drop = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 16; i++)
                add_burst(n, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
        run_phase("random", 3000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
